// File: rtl/wb_master_if_pkg.sv
// Shared types and constants for the Wishbone initiator.
//   wb_state_e : initiator FSM states (encodings fixed for waveform/debug tools)
//   wb_req_t   : latched bus request driven onto the wb_* outputs
package wb_master_if_pkg;

  localparam logic        RST_ENABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic [1:0] {
    WB_IDLE       = 2'b00,
    WB_BUSY       = 2'b01,
    WB_WAIT_STALL = 2'b10
  } wb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

endpackage

// File: rtl/wb_master_if.sv
// Wishbone classic single-access initiator for one MiniMIPS32 memory port.
// A one-cycle CPU request is latched onto the bus; the pipeline is held with
// stall_o until ack, timeout or flush. Read data arriving while the pipeline
// is stalled elsewhere is parked in rd_buf and presented from WAIT_STALL.
//   wb_clk_i / wb_rst_i     : clock, synchronous active-low reset
//   cpu_ce/we/addr/sel/data : CPU request (valid for one cycle in IDLE)
//   cpu_data_o, stall_o     : read data and stall request back to the pipeline
//   err_o                   : one-cycle pulse after a timeout abort
//   stall_i, flush_i        : pipeline stalled elsewhere / pipeline flush
//   wb_*                    : Wishbone initiator signals
module wb_master_if
  import wb_master_if_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_o,
  output logic        err_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  wb_state_e        state_q, state_d;
  wb_req_t          req_q, req_d;
  logic             cyc_q, cyc_d;
  logic [31:0]      rd_buf_q, rd_buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i == RST_ENABLE) begin
      state_q  <= WB_IDLE;
      req_q    <= '0;
      cyc_q    <= 1'b0;
      rd_buf_q <= ZERO_WORD;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cyc_q    <= cyc_d;
      rd_buf_q <= rd_buf_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cyc_d      = cyc_q;
    rd_buf_d   = rd_buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stall_o    = 1'b0;
    cpu_data_o = ZERO_WORD;

    case (state_q)
      WB_IDLE: begin
        // The err_o cycle belongs to the aborted access: a new request is
        // held off for that one cycle so err_o never overlaps stall_o.
        // Nothing is accepted while reset is asserted either.
        if (cpu_ce_i && !flush_i && !err_q && (wb_rst_i != RST_ENABLE)) begin
          stall_o   = 1'b1;
          req_d.we  = cpu_we_i;
          req_d.adr = cpu_addr_i;
          req_d.sel = cpu_sel_i;
          req_d.dat = cpu_data_i;
          cyc_d     = 1'b1;
          cnt_d     = '0;
          state_d   = WB_BUSY;
        end
      end

      WB_BUSY: begin
        stall_o = 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        // Priority: flush, then ack, then timeout.
        if (flush_i) begin
          stall_o  = 1'b0;
          cyc_d    = 1'b0;
          cnt_d    = '0;
          rd_buf_d = ZERO_WORD;
          state_d  = WB_IDLE;
        end else if (wb_ack_i) begin
          stall_o    = 1'b0;
          cpu_data_o = req_q.we ? ZERO_WORD : wb_dat_i;
          rd_buf_d   = req_q.we ? ZERO_WORD : wb_dat_i;
          cyc_d      = 1'b0;
          state_d    = stall_i ? WB_WAIT_STALL : WB_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stall_o = 1'b0;
          cyc_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = WB_IDLE;
        end
      end

      WB_WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
        if (flush_i) begin
          rd_buf_d = ZERO_WORD;
          state_d  = WB_IDLE;
        end else if (!stall_i) begin
          state_d = WB_IDLE;
        end
      end

      default: state_d = WB_IDLE;
    endcase
  end

  // cyc and stb are the same flop: single accesses only, no wait-stated stb.
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = req_q.we;
  assign wb_adr_o = req_q.adr;
  assign wb_dat_o = req_q.dat;
  assign wb_sel_o = req_q.sel;
  assign err_o    = err_q;

endmodule
